// File: rtl/reg_hazard_ctrl_pkg.sv
// Shared types and constants for the register hazard/forwarding controller.
// Forward-select codes, mul/div tracker states and scoreboard entry layout.
package reg_hazard_ctrl_pkg;

    localparam int REG_NUM_WIDTH     = 4;
    localparam int REG_FORWARD_WIDTH = 2;

    localparam logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_REG_FILE = 2'b00;
    localparam logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_WB       = 2'b01;
    localparam logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_R0       = 2'b10;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    typedef struct packed {
        logic                     valid;
        logic                     wr;
        logic [REG_NUM_WIDTH-1:0] wrn;
    } sb_entry_t;

    localparam int SB_ENTRY_WIDTH = $bits(sb_entry_t);

    function automatic logic sb_hit(
        input sb_entry_t                e,
        input logic                     used,
        input logic [REG_NUM_WIDTH-1:0] rn
    );
        return used && e.valid && e.wr && (e.wrn == rn);
    endfunction

    // R0 bypass wins over WB because the register file applies wr0 last.
    function automatic logic [REG_FORWARD_WIDTH-1:0] fwd_sel(
        input logic [REG_NUM_WIDTH-1:0] rn,
        input logic                     used,
        input logic                     md_done,
        input sb_entry_t                wb
    );
        if (rn == '0 && md_done)
            return REG_FORWARD_R0;
        else if (sb_hit(wb, used, rn))
            return REG_FORWARD_WB;
        else
            return REG_FORWARD_REG_FILE;
    endfunction

endpackage

// File: rtl/reg_hazard_ctrl_tracker.sv
// Mul/div R0 write tracker: IDLE/BUSY/DONE FSM with a latency down-counter.
// DONE lasts exactly one cycle and is the cycle the R0 write lands.
module muldiv_r0_tracker
    import reg_hazard_ctrl_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4,
    parameter int CNT_W = (MULDIV_LATENCY > 2) ? $clog2(MULDIV_LATENCY - 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULDIV_LATENCY - 2);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0)
                    state_d = MD_DONE;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            MD_DONE: begin
                if (start) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == MD_BUSY);
            done_q  <= (state_d == MD_DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign cnt  = cnt_q;

endmodule

// File: rtl/reg_hazard_ctrl.sv
// Hazard/forwarding controller: EX/MEM/WB write scoreboard plus the
// mul/div R0 tracker; drives forward selects, stall and wr0_en.
module reg_hazard_ctrl
    import reg_hazard_ctrl_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [REG_NUM_WIDTH-1:0]     id_rn_1,
    input  logic [REG_NUM_WIDTH-1:0]     id_rn_2,
    input  logic                         id_use_1,
    input  logic                         id_use_2,
    input  logic                         id_wr,
    input  logic [REG_NUM_WIDTH-1:0]     id_wrn,
    input  logic                         id_muldiv,
    input  logic                         flush,
    output logic [REG_FORWARD_WIDTH-1:0] reg_forward_1,
    output logic [REG_FORWARD_WIDTH-1:0] reg_forward_2,
    output logic                         stall,
    output logic                         wr0_en,
    output logic                         muldiv_busy
);

    localparam int CNT_W = (MULDIV_LATENCY > 2) ? $clog2(MULDIV_LATENCY - 1) : 1;

    sb_entry_t        ex_q, mem_q, wb_q;
    sb_entry_t        ex_d, mem_d, wb_d;
    logic             accept;
    logic             md_busy, md_done;
    logic [CNT_W-1:0] md_cnt;
    logic             hz_1, hz_2, r0_rd;

    muldiv_r0_tracker #(
        .MULDIV_LATENCY(MULDIV_LATENCY),
        .CNT_W         (CNT_W)
    ) u_tracker (
        .clk  (clk),
        .rst  (rst),
        .start(accept && id_muldiv),
        .busy (md_busy),
        .done (md_done),
        .cnt  (md_cnt)
    );

    always_comb begin
        hz_1  = sb_hit(ex_q, id_use_1, id_rn_1) || sb_hit(mem_q, id_use_1, id_rn_1);
        hz_2  = sb_hit(ex_q, id_use_2, id_rn_2) || sb_hit(mem_q, id_use_2, id_rn_2);
        r0_rd = (id_use_1 && id_rn_1 == '0) || (id_use_2 && id_rn_2 == '0);
        stall = id_valid && (hz_1 || hz_2 ||
                (md_busy && (r0_rd || id_muldiv || (id_wr && id_wrn == '0))));
        accept = id_valid && !stall;
        reg_forward_1 = fwd_sel(id_rn_1, id_use_1, md_done, wb_q);
        reg_forward_2 = fwd_sel(id_rn_2, id_use_2, md_done, wb_q);
    end

    // WB still takes the pre-flush MEM entry so older writes commit.
    always_comb begin
        ex_d = '0;
        if (accept && !flush) begin
            ex_d.valid = 1'b1;
            ex_d.wr    = id_wr;
            ex_d.wrn   = id_wrn;
        end
        mem_d = flush ? '0 : ex_q;
        wb_d  = mem_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign wr0_en      = md_done;
    assign muldiv_busy = md_busy;

    a_cnt_idle: assert property (@(posedge clk) disable iff (rst)
        !md_busy |-> md_cnt == '0);

endmodule

// File: tb/tb_reg_hazard_ctrl.sv
// Scoreboard bench for reg_hazard_ctrl: directed per-cycle vectors push
// expected outputs; a negedge monitor pops and compares.
module tb_reg_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [3:0] id_rn_1 = 4'd15;
    logic [3:0] id_rn_2 = 4'd15;
    logic       id_use_1 = 1'b0;
    logic       id_use_2 = 1'b0;
    logic       id_wr = 1'b0;
    logic [3:0] id_wrn = 4'd0;
    logic       id_muldiv = 1'b0;
    logic       flush = 1'b0;

    logic [1:0] f1_a, f2_a, f1_b, f2_b;
    logic       st_a, w0_a, bz_a, st_b, w0_b, bz_b;

    always #5 clk = ~clk;

    reg_hazard_ctrl #(.MULDIV_LATENCY(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rn_1(id_rn_1), .id_rn_2(id_rn_2),
        .id_use_1(id_use_1), .id_use_2(id_use_2),
        .id_wr(id_wr), .id_wrn(id_wrn), .id_muldiv(id_muldiv),
        .flush(flush), .reg_forward_1(f1_a), .reg_forward_2(f2_a),
        .stall(st_a), .wr0_en(w0_a), .muldiv_busy(bz_a)
    );

    reg_hazard_ctrl #(.MULDIV_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rn_1(id_rn_1), .id_rn_2(id_rn_2),
        .id_use_1(id_use_1), .id_use_2(id_use_2),
        .id_wr(id_wr), .id_wrn(id_wrn), .id_muldiv(id_muldiv),
        .flush(flush), .reg_forward_1(f1_b), .reg_forward_2(f2_b),
        .stall(st_b), .wr0_en(w0_b), .muldiv_busy(bz_b)
    );

    // {stall, fwd1, fwd2, wr0_en, muldiv_busy}
    wire [6:0] got_a = {st_a, f1_a, f2_a, w0_a, bz_a};
    wire [6:0] got_b = {st_b, f1_b, f2_b, w0_b, bz_b};

    typedef struct {
        bit         chk_a;
        bit         chk_b;
        logic [6:0] e;
        int         test;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t x;
    int   n_chk = 0;
    int   n_fail = 0;
    int   tgt = 2;   // 0: L=4 dut, 1: L=3 dut, 2: both, 3: none
    int   test_id = 0;
    int   cyc = 0;

    task automatic step(
        input logic v, input logic [3:0] r1, input logic u1,
        input logic [3:0] r2, input logic u2, input logic w,
        input logic [3:0] wn, input logic md, input logic fl,
        input logic rs, input logic [6:0] e
    );
        exp_t t;
        @(posedge clk);
        #1;
        id_valid = v; id_rn_1 = r1; id_use_1 = u1;
        id_rn_2 = r2; id_use_2 = u2; id_wr = w; id_wrn = wn;
        id_muldiv = md; flush = fl; rst = rs;
        t.chk_a = (tgt == 0 || tgt == 2);
        t.chk_b = (tgt == 1 || tgt == 2);
        t.e = e;
        t.test = test_id;
        t.cyc = cyc;
        q.push_back(t);
        cyc++;
    endtask

    task automatic idle(input int n, input logic [6:0] e);
        for (int i = 0; i < n; i++)
            step(0, 15, 0, 15, 0, 0, 0, 0, 0, 0, e);
    endtask

    task automatic begin_test(input int id, input int which);
        int keep;
        keep = which;
        test_id = id;
        tgt = 3;
        cyc = -1;
        step(0, 15, 0, 15, 0, 0, 0, 0, 0, 1, 7'b0);
        tgt = keep;
        idle(1, 7'b0);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            x = q.pop_front();
            if (x.chk_a) begin
                n_chk++;
                if (got_a !== x.e) begin
                    n_fail++;
                    $display("FAIL lat4 test%0d cyc%0d got=%b want=%b",
                             x.test, x.cyc, got_a, x.e);
                end
            end
            if (x.chk_b) begin
                n_chk++;
                if (got_b !== x.e) begin
                    n_fail++;
                    $display("FAIL lat3 test%0d cyc%0d got=%b want=%b",
                             x.test, x.cyc, got_b, x.e);
                end
            end
        end
    end

    initial begin
        // reset state, both instances
        begin_test(0, 2);
        idle(1, 7'b0_00_00_0_0);

        // RAW on R3: stall two cycles, then WB bypass on port 1
        begin_test(1, 2);
        step(1, 1, 1, 2, 1, 1, 3, 0, 0, 0, 7'b0_00_00_0_0);
        step(1, 3, 1, 4, 1, 1, 5, 0, 0, 0, 7'b1_00_00_0_0);
        step(1, 3, 1, 4, 1, 1, 5, 0, 0, 0, 7'b1_00_00_0_0);
        step(1, 3, 1, 4, 1, 1, 5, 0, 0, 0, 7'b0_01_00_0_0);
        idle(3, 7'b0);

        // independent back-to-back instructions
        begin_test(2, 2);
        step(1, 2, 1, 15, 0, 1, 1, 0, 0, 0, 7'b0);
        step(1, 5, 1, 6, 1, 1, 4, 0, 0, 0, 7'b0);
        step(1, 7, 1, 8, 1, 1, 9, 0, 0, 0, 7'b0);
        idle(3, 7'b0);

        // MUL (latency 4), R0 reader waits for DONE
        begin_test(3, 0);
        step(1, 1, 1, 2, 1, 0, 0, 1, 0, 0, 7'b0_00_00_0_0);
        step(1, 0, 1, 9, 1, 1, 6, 0, 0, 0, 7'b1_00_00_0_1);
        step(1, 0, 1, 9, 1, 1, 6, 0, 0, 0, 7'b1_00_00_0_1);
        step(1, 0, 1, 9, 1, 1, 6, 0, 0, 0, 7'b1_00_00_0_1);
        step(1, 0, 1, 9, 1, 1, 6, 0, 0, 0, 7'b0_10_00_1_0);
        idle(3, 7'b0);

        // latency 3: DONE meets WB write of R0; second MUL taken in DONE
        begin_test(4, 1);
        step(1, 1, 1, 2, 1, 1, 0, 1, 0, 0, 7'b0_00_00_0_0);
        step(1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 7'b1_00_00_0_1);
        step(1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 7'b1_00_00_0_1);
        step(1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 7'b0_10_10_1_0);
        idle(1, 7'b0_00_00_0_1);
        idle(1, 7'b0_00_00_0_1);
        idle(1, 7'b0_00_00_1_0);
        idle(1, 7'b0);

        // flush kills the R3 producer; reader proceeds next cycle
        begin_test(5, 2);
        step(1, 1, 1, 2, 1, 1, 3, 0, 0, 0, 7'b0);
        step(1, 4, 1, 3, 1, 1, 8, 0, 1, 0, 7'b1_00_00_0_0);
        step(1, 4, 1, 3, 1, 1, 8, 0, 0, 0, 7'b0_00_00_0_0);
        idle(3, 7'b0);

        // reset while BUSY with a full scoreboard
        begin_test(6, 0);
        step(1, 1, 1, 2, 1, 0, 0, 1, 0, 0, 7'b0_00_00_0_0);
        step(1, 1, 1, 15, 0, 1, 9, 0, 0, 0, 7'b0_00_00_0_1);
        step(1, 2, 1, 15, 0, 1, 10, 0, 0, 0, 7'b0_00_00_0_1);
        step(1, 9, 1, 15, 0, 1, 11, 0, 0, 1, 7'b1_00_00_0_1);
        idle(6, 7'b0);

        for (int i = 0; i < 4 && q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_hazard_ctrl.md
# reg_hazard_ctrl

Hazard and forwarding controller for the 16 x 16-bit register file. It tracks in-flight register writes through the EX/MEM/WB stages and the multi-cycle mul/div unit's pending R0 write. Each cycle it drives the register file's per-port forward selects, the R0 write-enable, and a decode-stage stall. It sits between decode and the register file and sequences every register-file access.

## Interface
Parameters:
- REG_NUM_WIDTH, 4, register-number width.
- REG_FORWARD_WIDTH, 2, forward-select width.
- REG_FORWARD_REG_FILE, 2'b00, read the register array.
- REG_FORWARD_WB, 2'b01, bypass WB write data.
- REG_FORWARD_R0, 2'b10, bypass mul/div R0 data.
- MULDIV_LATENCY, 4, cycles from mul/div acceptance to R0 write; legal values are 2 or more.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode holds an instruction.
- id_rn_1, id_rn_2  in  REG_NUM_WIDTH  source registers.
- id_use_1, id_use_2  in  1  the corresponding source is actually read.
- id_wr  in  1  the instruction writes id_wrn at WB.
- id_wrn  in  REG_NUM_WIDTH  destination register.
- id_muldiv  in  1  the instruction is a mul/div; its result goes to R0 via wr0.
- flush  in  1  kill the EX and MEM entries (branch redirect).
- reg_forward_1, reg_forward_2  out  REG_FORWARD_WIDTH  per-port forward selects.
- stall  out  1  hold decode and insert a bubble into EX.
- wr0_en  out  1  drives the register file's wr0.
- muldiv_busy  out  1  the mul/div unit is in state BUSY.

## Operation
- Scoreboard: three entries (EX, MEM, WB), each holding {valid, wr, wrn}.
- Each cycle: EX←ID, MEM←EX, WB←MEM.
- The ID instruction is "accepted" when id_valid && !stall. If it is not accepted, EX receives an invalid bubble.
- flush: EX and MEM become invalid on the next edge. WB still advances from MEM (pre-flush contents) and commits normally.
- Source match for port k: id_use_k && rn_k equals the entry's wrn && entry valid && entry wr.
- Forward select for port k, highest priority first:
  - REG_FORWARD_R0 if rn_k==0 and the FSM is in DONE (reg file applies wr0 last).
  - REG_FORWARD_WB if the WB entry matches.
  - Otherwise REG_FORWARD_REG_FILE.
- stall = id_valid && any of the following:
  - any used source matches the EX or MEM entry;
  - any used source is R0 while the FSM is BUSY;
  - id_muldiv while the FSM is BUSY;
  - id_wr && id_wrn==0 while the FSM is BUSY (WAW on R0).
- Mul/div FSM states:
  - IDLE → BUSY on an accepted id_muldiv.
  - BUSY → DONE after the latency count expires.
  - DONE → BUSY on an accepted id_muldiv, otherwise → IDLE.
- wr0_en = 1 only in DONE. muldiv_busy = 1 only in BUSY.
- A mul/div in flight is not cancelled by flush.
- A mul/div instruction with id_wr=0 occupies a scoreboard slot but never matches.
- Every instruction is checked against the WB entry (forward), not stalled on it.

## Timing
- reg_forward_1/2 and stall are combinational from ID inputs and registered state, valid in the same cycle.
- wr0_en and muldiv_busy are decoded directly from the registered FSM state.
- Mul/div accepted at the edge ending cycle t:
  - BUSY in cycles t+1 .. t+MULDIV_LATENCY-1;
  - DONE (wr0_en=1) in cycle t+MULDIV_LATENCY.
- Dependency distance: producer accepted in cycle t, dependent in ID at t+1 → stall in t+1 and t+2, forward from WB in t+3.
- Simultaneous WB write to R0 and DONE: forward R0 (matches reg-file write order).
- Reset: all scoreboard entries invalid, FSM IDLE, counter 0. All outputs 0 in the cycle after rst is sampled high. Outputs are 0 in any cycle where id_valid=0 and state is IDLE with an empty scoreboard.
- Reset mid-mul/div abandons the op with no wr0_en pulse.

## Structure
- Shared header/package reg_defs: forward-select codes, REG_NUM_WIDTH, FSM state encodings (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), scoreboard entry field widths.
- Natural sub-module: muldiv_r0_tracker, containing the FSM and latency counter. Its outputs are busy, done and the counter value.
- The top level holds the three-entry scoreboard and the combinational forward/stall logic.

## Test plan
- ADD writes R3 in cycle 0; SUB reads R3 (port 1) in cycle 1 → stall=1 in cycles 1–2; reg_forward_1=2'b01, stall=0 in cycle 3.
- Independent instructions back-to-back (R1←R2, R4←R5) → stall=0 every cycle, both selects 2'b00.
- MUL accepted in cycle 0 with MULDIV_LATENCY=4; reader of R0 in ID from cycle 1 → stall=1 in cycles 1–3; reg_forward=2'b10 and wr0_en=1 in cycle 4.
- DONE coincides with a WB write to R0 and an R0 reader → select 2'b10. A second MUL accepted in the DONE cycle → muldiv_busy=1 from the next cycle.
- R3 producer in EX, flush asserted while R3 reader waits → stall clears the cycle after flush, select 2'b00.
- rst asserted while BUSY with a full scoreboard → next cycle all outputs 0 and no later wr0_en pulse.
